// File: rtl/systolic_input_loader.sv
// systolic_input_loader
//
// Upstream stage of the systolic array. It accepts a host word stream (top matrix
// row-major, then left matrix row-major) over valid/ready. It packs the words into
// RAM lines of MEM_PORT_WIDTH bits and writes them to the input RAM. Once a complete
// operand set is stored it kicks off the matmul FSM. When that FSM reports ready
// again, it pulses load_done.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   load_start      1-cycle load request, honoured only when idle
//   in_valid/in_ready/in_data   host word stream (word 0 lands in the line LSBs)
//   mem_own         loader owns the RAM port (top-level mux select)
//   mem_addr, mem_wr_en, mem_wr_data   RAM line write port
//   fsm_rdy         matmul FSM ready
//   inputs_rdy      level: RAM holds a complete operand set
//   start_fsm, start_matmul   1-cycle start pulses, back to back
//   busy            not idle
//   load_done       1-cycle pulse when the run completes
module systolic_input_loader #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned MEM_PORT_WIDTH = 64,
  parameter int unsigned BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_SIZE-1:0]      in_data,
  output logic                      mem_own,
  output logic [31:0]               mem_addr,
  output logic                      mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] mem_wr_data,
  input  logic                      fsm_rdy,
  output logic                      inputs_rdy,
  output logic                      start_fsm,
  output logic                      start_matmul,
  output logic                      busy,
  output logic                      load_done
);

  localparam int unsigned Wpl   = MEM_PORT_WIDTH / WORD_SIZE;
  localparam int unsigned Total = 2 * ROWS * COLS;
  localparam int unsigned Lines = (Total + Wpl - 1) / Wpl;
  localparam int unsigned WordW = $clog2(Total + 1);
  localparam int unsigned SlotW = (Wpl > 1) ? $clog2(Wpl) : 1;
  localparam int unsigned LineW = $clog2(Lines + 1);

  if ((MEM_PORT_WIDTH % WORD_SIZE) != 0 || Wpl == 0) begin : g_bad_width
    $error("systolic_input_loader: MEM_PORT_WIDTH must be a multiple of WORD_SIZE");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StWaitRdy,
    StStart,
    StMatmul,
    StRun
  } state_e;

  state_e                    state_q, state_d;
  logic [WordW-1:0]          word_cnt_q, word_cnt_d;
  logic [SlotW-1:0]          slot_q, slot_d;
  logic [LineW-1:0]          line_cnt_q, line_cnt_d;
  logic [MEM_PORT_WIDTH-1:0] pack_q, pack_d;
  logic                      wr_en_q, wr_en_d;
  logic [MEM_PORT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [31:0]               addr_q, addr_d;
  logic                      seen_low_q, seen_low_d;
  logic                      load_done_q, load_done_d;

  logic                      accept;
  logic                      last_word;
  logic                      line_full;
  logic [MEM_PORT_WIDTH-1:0] line_word;

  assign accept    = in_valid && (state_q == StLoad);
  assign last_word = (word_cnt_q == WordW'(Total - 1));
  assign line_full = (slot_q == SlotW'(Wpl - 1));

  // Pack register with the incoming word merged into the current slot. The pack
  // register is cleared after every write, so untouched slots are already zero.
  always_comb begin
    line_word = pack_q;
    for (int k = 0; k < Wpl; k++) begin
      if (slot_q == SlotW'(k)) begin
        line_word[k*WORD_SIZE +: WORD_SIZE] = in_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    slot_d      = slot_q;
    line_cnt_d  = line_cnt_q;
    pack_d      = pack_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    addr_d      = addr_q;
    seen_low_d  = seen_low_q;
    load_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          slot_d     = '0;
          line_cnt_d = '0;
          pack_d     = '0;
          seen_low_d = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (line_full || last_word) begin
            // Line is registered now and appears on the write port next cycle.
            wr_en_d    = 1'b1;
            wr_data_d  = line_word;
            addr_d     = BASE_ADDR + 32'(line_cnt_q);
            line_cnt_d = line_cnt_q + 1'b1;
            slot_d     = '0;
            pack_d     = '0;
          end else begin
            pack_d = line_word;
            slot_d = slot_q + 1'b1;
          end
          if (last_word) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // The final line write is on the port during this cycle.
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (fsm_rdy) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StMatmul;
      end
      StMatmul: begin
        state_d    = StRun;
        seen_low_d = 1'b0;
      end
      StRun: begin
        // The run is over only once fsm_rdy has dropped and then come back.
        if (!fsm_rdy) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d     = StIdle;
          load_done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      slot_q      <= '0;
      line_cnt_q  <= '0;
      pack_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      addr_q      <= '0;
      seen_low_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      slot_q      <= slot_d;
      line_cnt_q  <= line_cnt_d;
      pack_q      <= pack_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      addr_q      <= addr_d;
      seen_low_q  <= seen_low_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    in_ready     = (state_q == StLoad);
    mem_own      = (state_q == StLoad) || (state_q == StFlush);
    mem_wr_en    = wr_en_q;
    mem_addr     = addr_q;
    mem_wr_data  = wr_data_q;
    inputs_rdy   = (state_q == StWaitRdy) || (state_q == StStart) ||
                   (state_q == StMatmul) || (state_q == StRun);
    start_fsm    = (state_q == StStart);
    start_matmul = (state_q == StMatmul);
    busy         = (state_q != StIdle);
    load_done    = load_done_q;
  end

endmodule

// File: tb/tb_systolic_input_loader.sv
// Bench for systolic_input_loader: a 4x4 instance (32 words, 8 lines) and a 3x3
// instance (18 words, 5 lines, last line zero-padded). Expected RAM writes are
// queued when a load is driven and popped as the DUT writes.
module tb_systolic_input_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk;
  logic        rst;

  logic        load_start, in_valid, in_ready, mem_own, mem_wr_en, fsm_rdy;
  logic        inputs_rdy, start_fsm, start_matmul, busy, load_done;
  logic [15:0] in_data;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;

  logic        load_start_b, in_valid_b, in_ready_b, mem_own_b, mem_wr_en_b, fsm_rdy_b;
  logic        inputs_rdy_b, start_fsm_b, start_matmul_b, busy_b, load_done_b;
  logic [15:0] in_data_b;
  logic [31:0] mem_addr_b;
  logic [63:0] mem_wr_data_b;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;
  int exp_done = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t wa, wb;

  systolic_input_loader #(
    .ROWS(4), .COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mem_own(mem_own), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .fsm_rdy(fsm_rdy),
    .inputs_rdy(inputs_rdy), .start_fsm(start_fsm), .start_matmul(start_matmul),
    .busy(busy), .load_done(load_done)
  );

  systolic_input_loader #(
    .ROWS(3), .COLS(3), .WORD_SIZE(16), .MEM_PORT_WIDTH(64), .BASE_ADDR(0)
  ) dut_b (
    .clk(clk), .rst(rst), .load_start(load_start_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_data(in_data_b), .mem_own(mem_own_b),
    .mem_addr(mem_addr_b), .mem_wr_en(mem_wr_en_b), .mem_wr_data(mem_wr_data_b),
    .fsm_rdy(fsm_rdy_b), .inputs_rdy(inputs_rdy_b), .start_fsm(start_fsm_b),
    .start_matmul(start_matmul_b), .busy(busy_b), .load_done(load_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference image: word i has value i, four 16-bit words per line, first word in LSBs.
  function automatic void push_image(input bit which, input int total);
    wr_t w;
    for (int l = 0; l * 4 < total; l++) begin
      w.addr = 32'(l);
      w.data = '0;
      for (int k = 0; k < 4; k++) begin
        if (l * 4 + k < total) w.data[k*16 +: 16] = 16'(l * 4 + k);
      end
      if (which) exp_b.push_back(w);
      else exp_a.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    if (load_done) n_done++;
    if (mem_wr_en) begin
      check_eq("a_wr_own", mem_own, 1);
      if (exp_a.size() == 0) begin
        check_eq("a_wr_extra", mem_wr_en, 0);
      end else begin
        wa = exp_a.pop_front();
        check_eq("a_wr_addr", mem_addr, wa.addr);
        check_eq("a_wr_data", mem_wr_data, wa.data);
      end
    end
    if (mem_wr_en_b) begin
      check_eq("b_wr_own", mem_own_b, 1);
      if (exp_b.size() == 0) begin
        check_eq("b_wr_extra", mem_wr_en_b, 0);
      end else begin
        wb = exp_b.pop_front();
        check_eq("b_wr_addr", mem_addr_b, wb.addr);
        check_eq("b_wr_data", mem_wr_data_b, wb.data);
      end
    end
  end

  task automatic check_idle_a(input string tag);
    check_eq({tag, "_flags"}, {in_ready, mem_own, mem_wr_en, inputs_rdy, start_fsm,
                              start_matmul, busy, load_done}, 8'h00);
    check_eq({tag, "_addr"}, mem_addr, 32'h0);
    check_eq({tag, "_data"}, mem_wr_data, 64'h0);
  endtask

  task automatic start_a();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Drive words 0..n-1; toggle inserts an idle cycle between valid cycles,
  // poke raises load_start mid-stream.
  task automatic send_a(input int n, input bit toggle, input bit poke);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < n && cyc < 500) begin
      in_valid   = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data    = in_valid ? 16'(i) : 16'hdead;
      load_start = poke && (i == 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    check_eq("a_send_cnt", 64'(i), 64'(n));
  endtask

  task automatic post_load_a();
    @(negedge clk);
    check_eq("a_flush", {mem_own, in_ready, mem_wr_en}, 3'b101);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("a_wait_rdy", {mem_own, inputs_rdy, mem_wr_en}, 3'b010);
    @(posedge clk); #1;
  endtask

  task automatic run_a(input bit stall);
    bit saw;
    if (stall) begin
      saw = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (start_fsm) saw = 1'b1;
        @(posedge clk); #1;
      end
      check_eq("a_stall_no_start", saw, 0);
    end
    fsm_rdy = 1'b1;
    @(negedge clk);
    check_eq("a_sf_early", {start_fsm, start_matmul}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("a_start_fsm", {start_fsm, start_matmul}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("a_start_mm", {start_fsm, start_matmul}, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("a_run", {start_fsm, start_matmul, busy, inputs_rdy}, 4'b0011);
    @(posedge clk); #1;
    // fsm_rdy still high: a stray load_start and no completion yet
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (load_done || !busy) saw = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("a_run_hold", saw, 0);
    fsm_rdy = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    fsm_rdy = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 10 && !saw; c++) begin
      @(negedge clk);
      if (load_done) begin
        saw = 1'b1;
        check_eq("a_done_state", {inputs_rdy, busy}, 2'b00);
      end
      @(posedge clk); #1;
    end
    check_eq("a_load_done", saw, 1);
    exp_done++;
    fsm_rdy = 1'b0;
  endtask

  initial begin
    bit acc;
    int i;
    int cyc;
    rst = 1'b1;
    load_start = 1'b0; in_valid = 1'b0; in_data = '0; fsm_rdy = 1'b0;
    load_start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; fsm_rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_a("a_reset");
    check_eq("b_reset", {in_ready_b, mem_own_b, mem_wr_en_b, inputs_rdy_b, busy_b}, 5'b0);
    @(posedge clk); #1;

    // Back-to-back stream with a stray load_start mid-load, stalled fsm_rdy.
    push_image(0, 32);
    start_a();
    send_a(32, 1'b0, 1'b1);
    post_load_a();
    check_eq("a_q_empty1", exp_a.size(), 0);
    run_a(1'b1);

    // Valid toggling each cycle: same image.
    push_image(0, 32);
    start_a();
    send_a(32, 1'b1, 1'b0);
    post_load_a();
    run_a(1'b0);

    // Reset after word 13: lines 0..2 written, partial line discarded.
    push_image(0, 12);
    start_a();
    send_a(14, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_a("a_abort");
    check_eq("a_abort_q", exp_a.size(), 0);
    @(posedge clk); #1;

    // Fresh load after the abort.
    push_image(0, 32);
    start_a();
    send_a(32, 1'b0, 1'b0);
    post_load_a();
    run_a(1'b0);

    // 3x3 instance: 18 words, 5 lines, last one zero-padded.
    push_image(1, 18);
    load_start_b = 1'b1;
    @(posedge clk); #1;
    load_start_b = 1'b0;
    i = 0;
    cyc = 0;
    while (i < 18 && cyc < 200) begin
      in_valid_b = 1'b1;
      in_data_b  = 16'(i);
      @(negedge clk);
      acc = in_valid_b && in_ready_b;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid_b = 1'b0;
    check_eq("b_send_cnt", 64'(i), 64'd18);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("b_wait_rdy", {inputs_rdy_b, mem_own_b, busy_b}, 3'b101);
    check_eq("b_q_empty", exp_b.size(), 0);

    check_eq("a_q_final", exp_a.size(), 0);
    check_eq("a_done_count", 64'(n_done), 64'(exp_done));
    check_eq("b_no_done", load_done_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
